// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Single-outstanding LW/SW engine between a core and a word-addressed data
// memory with combinational read data. A request is accepted only in IDLE; the
// effective byte address (base + sign-extended offset, mod 2^32) is checked
// for alignment and range at acceptance. Faulting requests go straight to
// RESP; good requests take ISSUE (store write pulse), optionally WAIT for
// RD_WAIT cycles, capture read data (loads) and then RESP.
//
// Handshakes (both sides use the same rule): a transfer happens on a rising
// clk edge where valid and ready are both 1. The producer keeps valid and its
// payload stable until that edge; ready may depend on state but never on
// valid.
//
// Parameters
//   MEM_WORDS  number of 32-bit words in the data memory
//   RD_WAIT    cycles between address issue and read-data capture (0..15)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_we                  1 = store, 0 = load
//   base, offset            byte base address, signed 16-bit immediate
//   wdata, rd_idx           store data, load destination tag
//   mem_we/addr/wdata       data memory write enable, word index, write data
//   mem_rdata               combinational read data at mem_addr
//   rsp_valid/rsp_ready     response handshake
//   rsp_data/rd_idx/fault   load data (0 for stores/faults), tag, fault flag
//   busy                    high whenever the FSM is not in IDLE
//   dbg_state               current FSM state encoding (IDLE=0 .. RESP=3)
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int MEM_WORDS = 32,
   parameter int RD_WAIT   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] base,
   input  logic [15:0] offset,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd_idx,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [4:0]  rsp_rd_idx,
   output logic        rsp_fault,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);
   // WAIT lasts RD_WAIT cycles: the counter is loaded with RD_WAIT-1 and
   // capture happens in the cycle where it reads zero.
   localparam logic [3:0]  WAIT_INIT   = 4'((RD_WAIT > 0) ? (RD_WAIT - 1) : 0);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] eff;
   logic        acc_fault;
   logic        accept;
   logic        capture;
   logic        we_q;
   logic [3:0]  wait_cnt;

   // Effective address and fault decision, only meaningful at acceptance.
   // Wrap-around past 2^32 is intentional: the sum is simply truncated.
   always_comb begin
      eff       = base + {{16{offset[15]}}, offset};
      acc_fault = (eff[1:0] != 2'b00) || ({2'b00, eff[31:2]} >= MEM_WORDS_L);
   end

   assign accept  = req_valid && (state == IDLE);
   assign capture = ((state == ISSUE) && (RD_WAIT == 0)) ||
                    ((state == WAIT) && (wait_cnt == 4'd0));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded outputs
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      busy      = 1'b1;
      rsp_valid = 1'b0;
      mem_we    = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               state_nxt = acc_fault ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            // Combinational from state so an asynchronous reset drops the
            // write pulse in the same instant.
            mem_we    = we_q;
            state_nxt = (RD_WAIT > 0) ? WAIT : RESP;
         end
         WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign dbg_state = state;

   // Request/response datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q       <= 1'b0;
         wait_cnt   <= 4'd0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         rsp_data   <= 32'd0;
         rsp_rd_idx <= 5'd0;
         rsp_fault  <= 1'b0;
      end else begin
         if (accept) begin
            we_q       <= req_we;
            mem_wdata  <= wdata;
            rsp_rd_idx <= rd_idx;
            rsp_fault  <= acc_fault;
            rsp_data   <= 32'd0;
            // A faulting access never touches memory, so no index is
            // presented for it.
            mem_addr   <= acc_fault ? 32'd0 : {2'b00, eff[31:2]};
         end

         if ((state == ISSUE) && (RD_WAIT > 0)) begin
            wait_cnt <= WAIT_INIT;
         end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end

         if (capture && !we_q) begin
            rsp_data <= mem_rdata;
         end

         if ((state == RESP) && rsp_ready) begin
            mem_addr <= 32'd0;
         end
      end
   end

endmodule
